// File: rtl/frame_buffer_writer.sv
// Write side of the raymarcher double-banked frame buffer: buffers shaded pixels,
// writes them to the fill bank and swaps banks at vblank. Option: FRAME_BUFFER_WRITER_BOUNDS_CHECK_EN.
module frame_buffer_writer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int CORDW      = 10,
    parameter int COLOR_W    = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CORDW-1:0]    in_x,
    input  logic [CORDW-1:0]    in_y,
    input  logic [COLOR_W-1:0]  in_color,
    input  logic                vblank_start,
    output logic                wr_en,
    output logic [ADDR_W:0]     wr_addr,
    output logic [COLOR_W-1:0]  wr_data,
    output logic                wr_bank,
    output logic                rd_bank,
    output logic                frame_done,
    output logic [15:0]         drop_count
);

    localparam int PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENTRY_W = 2 * CORDW + COLOR_W;
    localparam logic [CNT_W-1:0] LP_DEPTH  = CNT_W'(FIFO_DEPTH);
    localparam logic [CORDW-1:0] LP_X_LAST = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] LP_Y_LAST = CORDW'(V_RES - 1);
    localparam logic [31:0]      LP_HRES_BITS = 32'(H_RES);

    typedef enum logic [0:0] {
        ST_FILL      = 1'b0,
        ST_WAIT_SWAP = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic                 r_in_ready;
    logic [ENTRY_W-1:0]   r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_s1_valid;
    logic [CORDW-1:0]     r_s1_x;
    logic [CORDW-1:0]     r_s1_y;
    logic [COLOR_W-1:0]   r_s1_color;
    logic                 r_wr_en;
    logic [ADDR_W:0]      r_wr_addr;
    logic [COLOR_W-1:0]   r_wr_data;
    logic                 r_frame_done;
    logic [15:0]          r_drop_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_s1_last;
    logic                 w_s1_oob;
    logic                 w_s1_write;
    logic                 w_fill_next;
    logic [CNT_W-1:0]     w_count_next;
    logic [ENTRY_W-1:0]   w_head;

    // y*H_RES + x built from constant shifts of y, one per set bit of H_RES
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [CORDW-1:0] x,
                                                     input logic [CORDW-1:0] y);
        logic [ADDR_W+CORDW-1:0] acc;
        acc = {{ADDR_W{1'b0}}, x};
        for (int i = 0; i < ADDR_W; i++) begin
            if (LP_HRES_BITS[i]) begin
                acc = acc + ({{ADDR_W{1'b0}}, y} << i);
            end
        end
        return acc[ADDR_W-1:0];
    endfunction

    assign w_push    = in_valid && r_in_ready;
    assign w_s1_last = r_s1_valid && (r_s1_x == LP_X_LAST) && (r_s1_y == LP_Y_LAST);
    // Holding pops while the last pixel sits in stage 1 keeps next-frame pixels queued
    assign w_pop     = (r_state == ST_FILL) && (r_count != {CNT_W{1'b0}}) && !w_s1_last;
    assign w_head    = r_fifo_mem[r_rptr];
    assign w_count_next = r_count + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};
    assign w_fill_next  = (r_state == ST_FILL) ? !w_s1_last : vblank_start;

`ifdef FRAME_BUFFER_WRITER_BOUNDS_CHECK_EN
    assign w_s1_oob   = (r_s1_x > LP_X_LAST) || (r_s1_y > LP_Y_LAST);
`else
    assign w_s1_oob   = 1'b0;
`endif
    assign w_s1_write = r_s1_valid && !w_s1_oob;

    // FIFO storage; contents need no reset since the count defines validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wptr] <= {in_x, in_y, in_color};
        end
    end

    // Control FSM, FIFO pointers and the two-stage write pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_FILL;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b1;
            r_in_ready   <= 1'b0;
            r_wptr       <= {PTR_W{1'b0}};
            r_rptr       <= {PTR_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_s1_valid   <= 1'b0;
            r_s1_x       <= {CORDW{1'b0}};
            r_s1_y       <= {CORDW{1'b0}};
            r_s1_color   <= {COLOR_W{1'b0}};
            r_wr_en      <= 1'b0;
            r_wr_addr    <= {(ADDR_W+1){1'b0}};
            r_wr_data    <= {COLOR_W{1'b0}};
            r_frame_done <= 1'b0;
            r_drop_count <= 16'd0;
        end else begin
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < LP_DEPTH) && w_fill_next;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
                {r_s1_x, r_s1_y, r_s1_color} <= w_head;
            end
            r_s1_valid   <= w_pop;
            r_wr_en      <= w_s1_write;
            r_frame_done <= w_s1_last;
            if (r_s1_valid) begin
                r_wr_addr <= {r_wr_bank, pixel_addr(r_s1_x, r_s1_y)};
                r_wr_data <= r_s1_color;
            end
`ifdef FRAME_BUFFER_WRITER_BOUNDS_CHECK_EN
            if (r_s1_valid && w_s1_oob && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
`endif
            case (r_state)
                ST_FILL: begin
                    if (w_s1_last) begin
                        r_state <= ST_WAIT_SWAP;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (vblank_start) begin
                        r_state   <= ST_FILL;
                        r_wr_bank <= ~r_wr_bank;
                        r_rd_bank <= ~r_rd_bank;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_bank    = r_wr_bank;
    assign rd_bank    = r_rd_bank;
    assign frame_done = r_frame_done;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: scoreboard of expected writes checked
// at every wr_en, plus reset, swap, stall and bounds scenarios.
module tb_frame_buffer_writer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic [9:0]  in_color;
    logic        vblank_start;
    logic        wr_en;
    logic [19:0] wr_addr;
    logic [9:0]  wr_data;
    logic        wr_bank;
    logic        rd_bank;
    logic        frame_done;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int fd_count = 0;
    int run_len = 0;
    int max_run = 0;
    int wr_snap;
    bit fill_bank = 1'b0;
    logic [29:0] sb [$];

`ifdef FRAME_BUFFER_WRITER_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    frame_buffer_writer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_color     (in_color),
        .vblank_start (vblank_start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_bank      (wr_bank),
        .rd_bank      (rd_bank),
        .frame_done   (frame_done),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one pixel, wait (bounded) for acceptance, record the expected write
    task automatic send(input int x, input int y, input logic [9:0] c, input bit expect_wr);
        bit ok;
        int addr;
        ok = 1'b0;
        in_valid = 1'b1;
        in_x = 10'(x);
        in_y = 10'(y);
        in_color = c;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept", {31'd0, ok}, 32'd1);
        if (ok && expect_wr) begin
            addr = (y * 640 + x) % (1 << 19);
            sb.push_back({fill_bank, 19'(addr), c});
        end
    endtask

    task automatic pulse_vblank();
        @(posedge clk);
        #1 vblank_start = 1'b1;
        @(posedge clk);
        #1 vblank_start = 1'b0;
    endtask

    // Scoreboard side: every write must match the oldest expected entry
    always @(negedge clk) begin
        if (reset_n === 1'b1 && wr_en === 1'b1) begin
            logic [29:0] e;
            wr_total++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            check("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", {12'd0, wr_addr}, {12'd0, e[29:10]});
                check("wr_data", {22'd0, wr_data}, {22'd0, e[9:0]});
                check("frame_done_on_last", {31'd0, frame_done},
                      {31'd0, (e[28:10] == 19'd307199)});
            end
        end else begin
            run_len = 0;
            if (reset_n === 1'b1) check("frame_done_without_wr", {31'd0, frame_done}, 32'd0);
        end
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_x = 10'd0;
        in_y = 10'd0;
        in_color = 10'd0;
        vblank_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {12'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {22'd0, wr_data}, 32'd0);
        check("rst_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("rst_rd_bank", {31'd0, rd_bank}, 32'd1);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_drop_count", {16'd0, drop_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

        // Single pixel latency
        send(3, 2, 10'h2AB, 1'b1);
        @(negedge clk);
        check("lat_n0", {31'd0, wr_en}, 32'd0);
        @(negedge clk);
        check("lat_n1", {31'd0, wr_en}, 32'd0);
        @(negedge clk);
        check("lat_n2_wr_en", {31'd0, wr_en}, 32'd1);
        check("lat_addr", {12'd0, wr_addr}, 32'd1283);
        check("lat_data", {22'd0, wr_data}, 32'h2AB);
        repeat (3) @(negedge clk);

        // Back-to-back stream of 16
        for (int i = 0; i < 16; i++) begin
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            send(20 + i, 7, 10'(i * 37), 1'b1);
        end
        repeat (5) @(negedge clk);
        check("stream_run", max_run, 32'd16);
        check("stream_drained", sb.size(), 32'd0);

        // Last pixel then three more: two queue, the third waits for the swap
        send(639, 479, 10'h3FF, 1'b1);
        fill_bank = 1'b1;
        send(10, 10, 10'h0A1, 1'b1);
        send(11, 10, 10'h0A2, 1'b1);
        in_valid = 1'b1;
        in_x = 10'd12;
        in_y = 10'd10;
        in_color = 10'h0A3;
        for (int k = 0; k < 10 && fd_count == 0; k++) @(negedge clk);
        check("frame_done_seen", fd_count, 32'd1);
        wr_snap = wr_total;
        repeat (6) @(negedge clk);
        check("no_write_in_wait", wr_total, wr_snap);
        check("wait_in_ready", {31'd0, in_ready}, 32'd0);
        check("wait_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("wait_rd_bank", {31'd0, rd_bank}, 32'd1);
        pulse_vblank();
        check("swap_wr_bank", {31'd0, wr_bank}, 32'd1);
        check("swap_rd_bank", {31'd0, rd_bank}, 32'd0);
        send(12, 10, 10'h0A3, 1'b1);
        repeat (6) @(negedge clk);
        check("queued_drained", sb.size(), 32'd0);
        check("queued_write_count", wr_total - wr_snap, 32'd3);

        // vblank coincident with the FILL->WAIT_SWAP edge is ignored
        send(639, 479, 10'h155, 1'b1);
        fill_bank = 1'b0;
        @(posedge clk);
        #1 vblank_start = 1'b1;
        @(posedge clk);
        #1 vblank_start = 1'b0;
        repeat (4) @(negedge clk);
        check("coinc_no_swap", {31'd0, wr_bank}, 32'd1);
        check("coinc_in_ready", {31'd0, in_ready}, 32'd0);
        check("coinc_frame_done", fd_count, 32'd2);
        pulse_vblank();
        check("coinc_late_swap_wr", {31'd0, wr_bank}, 32'd0);
        check("coinc_late_swap_rd", {31'd0, rd_bank}, 32'd1);
        repeat (2) @(negedge clk);

        // Async reset with pixels in flight
        send(1, 1, 10'h001, 1'b1);
        send(2, 1, 10'h002, 1'b1);
        send(3, 1, 10'h003, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        sb.delete();
        wr_snap = wr_total;
        repeat (3) @(negedge clk);
        check("mid_rst_no_write", wr_total, wr_snap);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b1;
        fill_bank = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_wr_bank", {31'd0, wr_bank}, 32'd0);
        check("post_rst_rd_bank", {31'd0, rd_bank}, 32'd1);
        repeat (4) @(negedge clk);
        check("post_rst_no_write", wr_total, wr_snap);

        // Out-of-range coordinates
        wr_snap = wr_total;
        send(640, 0, 10'h011, !BOUNDS);
        send(0, 480, 10'h022, !BOUNDS);
        send(5, 5, 10'h033, 1'b1);
        repeat (6) @(negedge clk);
        check("oob_drop_count", {16'd0, drop_count}, BOUNDS ? 32'd2 : 32'd0);
        check("oob_write_count", wr_total - wr_snap, BOUNDS ? 32'd1 : 32'd3);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
